rip_hazard_ctrl: RTL and testbench

- Pipeline sequencer for the decode stage. It generates the de_ready / ex_stall pair that gates the decode registers, plus a fetch hold.
- It resolves three conditions: load-use interlocks, multi-cycle memory stalls, and control-flow redirect flushes.
- It sits between fetch, decode and EX/MEM. Operand numbers are decoded from the raw fetched word, so there is no loop through decode's de_ready-gated register-number outputs.
- It also keeps stall and flush cycle counters for performance analysis.

---
 rtl/rip_hazard_ctrl.sv | 123 ++++++++++++
 tb/tb_rip_hazard_ctrl.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/rip_hazard_ctrl.sv
// Decode-stage hazard sequencer: load-use interlock, memory stall and redirect flush.
// Drives de_ready/ex_stall/if_stall and keeps stall/flush performance counters.
module rip_hazard_ctrl #(
    parameter int FLUSH_CYCLES = 2,
    parameter int CNT_W        = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             if_valid,
    input  logic [31:0]      if_inst_code,
    input  logic [4:0]       de_rd_num,
    input  logic             de_is_load,
    input  logic             mem_busy,
    input  logic             ex_redirect,
    output logic             de_ready,
    output logic             ex_stall,
    output logic             if_stall,
    output logic             flushing,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    // state | meaning
    // RUN   | normal issue, load-use interlock and redirect acceptance
    // FLUSH | decode bubbles after a redirect, cnt_q counts remaining bubbles
    typedef enum logic {RUN = 1'b0, FLUSH = 1'b1} state_t;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;
    localparam logic [2:0] RELOAD     = 3'(FLUSH_CYCLES - 2);

    state_t           state_q, state_d;
    logic [2:0]       cnt_q, cnt_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [4:0] rs1, rs2;
    logic       rs1_used, rs2_used, is_csr_reg, load_use;
    logic       de_ready_c, ex_stall_c, if_stall_c, flushing_c, redirect_acc;
    logic       unused_inst_bits;

    assign opcode = if_inst_code[6:0];
    assign funct3 = if_inst_code[14:12];
    assign rs1    = if_inst_code[19:15];
    assign rs2    = if_inst_code[24:20];
    assign unused_inst_bits = ^{if_inst_code[31:25], if_inst_code[11:7]};

    // CSRRW/CSRRS/CSRRC read rs1; the immediate CSR forms and ECALL/EBREAK do not
    assign is_csr_reg = (opcode == OPC_SYSTEM) &&
                        ((funct3 == 3'b001) || (funct3 == 3'b010) || (funct3 == 3'b011));

    assign rs1_used = (opcode == OPC_OP) || (opcode == OPC_OP_IMM) || (opcode == OPC_LOAD) ||
                      (opcode == OPC_STORE) || (opcode == OPC_BRANCH) || (opcode == OPC_JALR) ||
                      is_csr_reg;
    assign rs2_used = (opcode == OPC_OP) || (opcode == OPC_STORE) || (opcode == OPC_BRANCH);

    assign load_use = if_valid && de_is_load && (de_rd_num != 5'd0) &&
                      ((rs1_used && (rs1 == de_rd_num)) || (rs2_used && (rs2 == de_rd_num)));

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        de_ready_c   = 1'b0;
        ex_stall_c   = 1'b0;
        if_stall_c   = 1'b0;
        redirect_acc = 1'b0;
        flushing_c   = (state_q == FLUSH);

        if (mem_busy) begin
            ex_stall_c = 1'b1;
            if_stall_c = 1'b1;
        end else if (ex_redirect) begin
            redirect_acc = 1'b1;
            if (FLUSH_CYCLES > 1) begin
                state_d = FLUSH;
                cnt_d   = RELOAD;
            end
        end else if (state_q == FLUSH) begin
            if (cnt_q == 3'd0) begin
                state_d = RUN;
            end else begin
                cnt_d = cnt_q - 3'd1;
            end
        end else if (load_use) begin
            if_stall_c = 1'b1;
        end else begin
            de_ready_c = if_valid;
        end

        stall_cnt_d = stall_cnt_q + (if_stall_c ? CNT_W'(1) : CNT_W'(0));
        flush_cnt_d = flush_cnt_q + ((flushing_c || redirect_acc) ? CNT_W'(1) : CNT_W'(0));
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= RUN;
            cnt_q       <= 3'd0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    // Outputs are forced low for the whole time reset is held
    assign de_ready  = rst_n & de_ready_c;
    assign ex_stall  = rst_n & ex_stall_c;
    assign if_stall  = rst_n & if_stall_c;
    assign flushing  = rst_n & flushing_c;
    assign stall_cnt = rst_n ? stall_cnt_q : '0;
    assign flush_cnt = rst_n ? flush_cnt_q : '0;

endmodule

// File: tb/tb_rip_hazard_ctrl.sv
// Directed bench for rip_hazard_ctrl: expected outputs queued per step, compared mid-cycle.
module tb_rip_hazard_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        if_valid;
    logic [31:0] if_inst_code;
    logic [4:0]  de_rd_num;
    logic        de_is_load;
    logic        mem_busy;
    logic        ex_redirect;
    logic        de_ready, ex_stall, if_stall, flushing;
    logic [31:0] stall_cnt, flush_cnt;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string       tag;
        logic        dr;
        logic        es;
        logic        is;
        logic        fl;
        logic [31:0] sc;
        logic [31:0] fc;
    } exp_t;

    exp_t sb[$];

    localparam logic [31:0] ADD_X3  = 32'h002081B3; // add  x3,x1,x2
    localparam logic [31:0] ADD_X6  = 32'h00128333; // add  x6,x5,x1
    localparam logic [31:0] ADD_X0  = 32'h00000333; // add  x6,x0,x0
    localparam logic [31:0] LUI_X5  = 32'h0002B2B7; // lui  x5 (rs1 field = 5)
    localparam logic [31:0] ADDI_5  = 32'h00508313; // addi x6,x1,5 (rs2 field = 5)
    localparam logic [31:0] SW_X5   = 32'h00512023; // sw   x5,0(x2)
    localparam logic [31:0] CSRW_X5 = 32'h30029073; // csrrw x0,mstatus,x5

    rip_hazard_ctrl #(.FLUSH_CYCLES(2), .CNT_W(32)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .if_valid     (if_valid),
        .if_inst_code (if_inst_code),
        .de_rd_num    (de_rd_num),
        .de_is_load   (de_is_load),
        .mem_busy     (mem_busy),
        .ex_redirect  (ex_redirect),
        .de_ready     (de_ready),
        .ex_stall     (ex_stall),
        .if_stall     (if_stall),
        .flushing     (flushing),
        .stall_cnt    (stall_cnt),
        .flush_cnt    (flush_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive one cycle of stimulus, queue its expectation, compare at the falling edge.
    task automatic step(input string tag, input logic rst, input logic v, input logic [31:0] inst,
                        input logic [4:0] rd, input logic ld, input logic busy, input logic redir,
                        input logic e_dr, input logic e_es, input logic e_is, input logic e_fl,
                        input logic [31:0] e_sc, input logic [31:0] e_fc);
        exp_t e;
        exp_t got;
        rst_n        = rst;
        if_valid     = v;
        if_inst_code = inst;
        de_rd_num    = rd;
        de_is_load   = ld;
        mem_busy     = busy;
        ex_redirect  = redir;
        e = '{tag, e_dr, e_es, e_is, e_fl, e_sc, e_fc};
        sb.push_back(e);
        @(negedge clk);
        got = sb.pop_front();
        check({got.tag, ".de_ready"},  {31'd0, de_ready}, {31'd0, got.dr});
        check({got.tag, ".ex_stall"},  {31'd0, ex_stall}, {31'd0, got.es});
        check({got.tag, ".if_stall"},  {31'd0, if_stall}, {31'd0, got.is});
        check({got.tag, ".flushing"},  {31'd0, flushing}, {31'd0, got.fl});
        check({got.tag, ".stall_cnt"}, stall_cnt, got.sc);
        check({got.tag, ".flush_cnt"}, flush_cnt, got.fc);
        checks++;
        assert (!(de_ready && ex_stall)) else begin
            errors++;
            $error("FAIL %s.ready_stall_excl observed=1 expected=0", got.tag);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; if_valid = 1'b0; if_inst_code = '0; de_rd_num = '0;
        de_is_load = 1'b0; mem_busy = 1'b0; ex_redirect = 1'b0;
        #1;
        //    tag          rst v  inst     rd ld bsy rdr  dr es is fl sc fc
        step("reset0",     0, 1, ADD_X3,  0, 0, 0, 0,    0, 0, 0, 0, 0, 0);
        step("reset_busy", 0, 1, ADD_X6,  5, 1, 1, 1,    0, 0, 0, 0, 0, 0);
        step("normal0",    1, 1, ADD_X3,  4, 0, 0, 0,    1, 0, 0, 0, 0, 0);
        step("normal1",    1, 1, ADD_X3,  3, 0, 0, 0,    1, 0, 0, 0, 0, 0);
        step("normal2",    1, 1, ADD_X3,  3, 0, 0, 0,    1, 0, 0, 0, 0, 0);
        step("ldu_add",    1, 1, ADD_X6,  5, 1, 0, 0,    0, 0, 1, 0, 0, 0);
        step("ldu_clear",  1, 1, ADD_X6,  5, 0, 0, 0,    1, 0, 0, 0, 1, 0);
        step("ld_x0",      1, 1, ADD_X0,  0, 1, 0, 0,    1, 0, 0, 0, 1, 0);
        step("lui_nouse",  1, 1, LUI_X5,  5, 1, 0, 0,    1, 0, 0, 0, 1, 0);
        step("addi_nors2", 1, 1, ADDI_5,  5, 1, 0, 0,    1, 0, 0, 0, 1, 0);
        step("ldu_sw",     1, 1, SW_X5,   5, 1, 0, 0,    0, 0, 1, 0, 1, 0);
        step("sw_clear",   1, 1, SW_X5,   5, 0, 0, 0,    1, 0, 0, 0, 2, 0);
        step("ldu_csr",    1, 1, CSRW_X5, 5, 1, 0, 0,    0, 0, 1, 0, 2, 0);
        step("invalid",    1, 0, ADD_X6,  5, 1, 0, 0,    0, 0, 0, 0, 3, 0);
        step("redir_n",    1, 1, ADD_X3,  3, 0, 0, 1,    0, 0, 0, 0, 3, 0);
        step("redir_n1",   1, 1, ADD_X3,  3, 0, 0, 0,    0, 0, 0, 1, 3, 1);
        step("redir_n2",   1, 1, ADD_X3,  3, 0, 0, 0,    1, 0, 0, 0, 3, 2);
        step("redir_ldu",  1, 1, ADD_X6,  5, 1, 0, 1,    0, 0, 0, 0, 3, 2);
        step("flush_ldu",  1, 1, ADD_X6,  5, 1, 0, 0,    0, 0, 0, 1, 3, 3);
        step("after_fl",   1, 1, ADD_X3,  3, 0, 0, 0,    1, 0, 0, 0, 3, 4);
        step("busy0",      1, 1, ADD_X3,  3, 0, 1, 1,    0, 1, 1, 0, 3, 4);
        step("busy1",      1, 1, ADD_X3,  3, 0, 1, 1,    0, 1, 1, 0, 4, 4);
        step("busy2",      1, 1, ADD_X3,  3, 0, 1, 1,    0, 1, 1, 0, 5, 4);
        step("busy_done",  1, 1, ADD_X3,  3, 0, 0, 0,    1, 0, 0, 0, 6, 4);
        step("rl_redir",   1, 1, ADD_X3,  3, 0, 0, 1,    0, 0, 0, 0, 6, 4);
        step("rl_reload",  1, 1, ADD_X3,  3, 0, 0, 1,    0, 0, 0, 1, 6, 5);
        step("rl_flush",   1, 1, ADD_X3,  3, 0, 0, 0,    0, 0, 0, 1, 6, 6);
        step("rl_run",     1, 1, ADD_X3,  3, 0, 0, 0,    1, 0, 0, 0, 6, 7);
        step("mf_redir",   1, 1, ADD_X3,  3, 0, 0, 1,    0, 0, 0, 0, 6, 7);
        step("mf_reset",   0, 1, ADD_X3,  3, 0, 0, 0,    0, 0, 0, 0, 0, 0);
        step("mf_run",     1, 1, ADD_X3,  3, 0, 0, 0,    1, 0, 0, 0, 0, 0);
        step("ms_busy",    1, 1, ADD_X3,  3, 0, 1, 0,    0, 1, 1, 0, 0, 0);
        step("ms_reset",   0, 1, ADD_X3,  3, 0, 1, 0,    0, 0, 0, 0, 0, 0);
        step("ms_run",     1, 1, ADD_X3,  3, 0, 0, 0,    1, 0, 0, 0, 0, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
